mic_level_encoder: RTL and testbench

//  Converts the 12-bit microphone sample stream into the 16-bit thermometer volume code consumed by the OLED soundbar

---
 rtl/mic_level_encoder_pkg.sv | 16 +
 rtl/mic_level_encoder_level_thermo.sv | 17 +
 rtl/mic_level_encoder.sv | 145 ++++++++++++++
 tb/tb_mic_level_encoder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_level_encoder_pkg.sv
// Shared constants and types for the microphone level path and the display
// helpers that consume its thermometer code.
package mic_level_encoder_pkg;

    localparam int LEVELS         = 16;
    localparam int LEVEL_W        = 5;
    localparam int THERM_W        = 16;
    localparam int SAMPLE_W_DEF   = 12;
    localparam int MID_DEF        = 2048;
    localparam int FLOOR_DEF      = 64;
    localparam int STEP_SHIFT_DEF = 7;

    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [THERM_W-1:0] therm_t;

endpackage

// File: rtl/mic_level_encoder_level_thermo.sv
// Combinational level -> thermometer converter: level n gives n ones, LSB-aligned.
// Any level at or above THERM_W saturates to all ones.
module level_thermo
    import mic_level_encoder_pkg::*;
(
    input  level_t level,
    output therm_t therm
);

    always_comb begin
        therm = '0;
        for (int i = 0; i < THERM_W; i++) begin
            therm[i] = (level > level_t'(i));
        end
    end

endmodule

// File: rtl/mic_level_encoder.sv
// Microphone sample stream -> peak-hold volume level and thermometer code,
// one result per window of WINDOW valid samples, three-stage pipeline.
module mic_level_encoder
    import mic_level_encoder_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int WINDOW     = 4000,
    parameter int MID        = MID_DEF,
    parameter int FLOOR      = FLOOR_DEF,
    parameter int STEP_SHIFT = STEP_SHIFT_DEF,
    parameter int DECAY_STEP = 1
)(
    input  logic                clock,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                hold,
    output level_t              level,
    output therm_t              tester,
    output logic                level_valid
);

    localparam int DEV_W = SAMPLE_W - 1;
    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [DEV_W-1:0] DEV_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    // |diff| with saturation; only the single most negative deviation exceeds DEV_MAX
    function automatic logic [DEV_W-1:0] sat_dev(input logic signed [SAMPLE_W:0] diff);
        logic [SAMPLE_W:0] mag;
        mag = (diff < 0) ? -diff : diff;
        if (mag > SAMPLE_W'(DEV_MAX))
            return DEV_MAX;
        return mag[DEV_W-1:0];
    endfunction

    function automatic level_t quantise(input logic [DEV_W-1:0] d);
        logic [DEV_W-1:0] over;
        logic [DEV_W-1:0] steps;
        if (d <= DEV_W'(FLOOR))
            return '0;
        over  = d - DEV_W'(FLOOR);
        steps = over >> STEP_SHIFT;
        if (steps >= DEV_W'(LEVELS))
            return level_t'(LEVELS);
        return level_t'(steps + DEV_W'(1));
    endfunction

    // Rises instantly, falls by at most DECAY_STEP, never below the new raw level
    function automatic level_t decay(input level_t raw, input level_t cur);
        level_t dstep;
        level_t fl;
        if (raw >= cur)
            return raw;
        dstep = level_t'(DECAY_STEP);
        fl    = (cur > dstep) ? (cur - dstep) : '0;
        return (raw > fl) ? raw : fl;
    endfunction

    logic signed [SAMPLE_W:0] diff;
    logic [DEV_W-1:0]         dev;
    logic [DEV_W-1:0]         peak_next;

    logic [DEV_W-1:0] peak_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic [DEV_W-1:0] snap_p0;
    logic             vld_p0;

    level_t           raw_p1;
    logic             vld_p1;

    level_t           level_p2;
    therm_t           tester_p2;
    logic             vld_p2;

    level_t           level_next;
    therm_t           therm_next;

    assign diff      = $signed({1'b0, sample}) - $signed((SAMPLE_W+1)'(MID));
    assign dev       = sat_dev(diff);
    assign peak_next = (dev > peak_p0) ? dev : peak_p0;

    // ACC: the closing sample is folded into the snapshot, so no sample falls between windows
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            peak_p0 <= '0;
            cnt_p0  <= '0;
            snap_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (sample_valid) begin
                if (cnt_p0 == CNT_LAST) begin
                    snap_p0 <= peak_next;
                    vld_p0  <= 1'b1;
                    peak_p0 <= '0;
                    cnt_p0  <= '0;
                end else begin
                    peak_p0 <= peak_next;
                    cnt_p0  <= cnt_p0 + 1'b1;
                end
            end
        end
    end

    // QUANT
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            raw_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0)
                raw_p1 <= quantise(snap_p0);
        end
    end

    assign level_next = decay(raw_p1, level_p2);

    level_thermo u_thermo (
        .level (level_next),
        .therm (therm_next)
    );

    // UPDATE: hold drops the whole result, including the pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_p2  <= '0;
            tester_p2 <= '0;
            vld_p2    <= 1'b0;
        end else begin
            vld_p2 <= 1'b0;
            if (vld_p1 && !hold) begin
                level_p2  <= level_next;
                tester_p2 <= therm_next;
                vld_p2    <= 1'b1;
            end
        end
    end

    assign level       = level_p2;
    assign tester      = tester_p2;
    assign level_valid = vld_p2;

endmodule

// File: tb/tb_mic_level_encoder.sv
// Bench for mic_level_encoder: a WINDOW=4 and a WINDOW=1 instance, each checked
// against a window-level behavioural model plus directed tables and sequences.
module tb_mic_level_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        sv4, hold4, lv4, sv1, hold1, lv1;
    logic [11:0] s4, s1;
    logic [4:0]  lvl4, lvl1;
    logic [15:0] t4, t1;

    always #5 clock = ~clock;

    mic_level_encoder #(.WINDOW(4)) u_dut4 (
        .clock(clock), .reset(reset), .sample_valid(sv4), .sample(s4), .hold(hold4),
        .level(lvl4), .tester(t4), .level_valid(lv4)
    );

    mic_level_encoder #(.WINDOW(1)) u_dut1 (
        .clock(clock), .reset(reset), .sample_valid(sv1), .sample(s1), .hold(hold1),
        .level(lvl1), .tester(t1), .level_valid(lv1)
    );

    int checks = 0;
    int failures = 0;
    int pulses4 = 0;
    int pulses1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: whole windows, plain arithmetic
    int m_peak[2];
    int m_cnt[2];
    int m_lvl[2];
    int win_len[2] = '{4, 1};
    int expq4[$];
    int expq1[$];

    function automatic int dev_of(input int s);
        int d;
        d = s - 2048;
        if (d < 0) d = -d;
        if (d > 2047) d = 2047;
        return d;
    endfunction

    function automatic int quant(input int d);
        int q;
        if (d <= 64) return 0;
        q = (d - 64) / 128 + 1;
        return (q > 16) ? 16 : q;
    endfunction

    function automatic int next_level(input int raw, input int cur);
        if (raw >= cur) return raw;
        return (cur - 1 > raw) ? cur - 1 : raw;
    endfunction

    task automatic model_sample(input int id, input int s, input bit h);
        int raw;
        if (dev_of(s) > m_peak[id]) m_peak[id] = dev_of(s);
        m_cnt[id]++;
        if (m_cnt[id] == win_len[id]) begin
            raw = quant(m_peak[id]);
            m_peak[id] = 0;
            m_cnt[id] = 0;
            if (!h) begin
                m_lvl[id] = next_level(raw, m_lvl[id]);
                if (id == 0) expq4.push_back(m_lvl[id]);
                else expq1.push_back(m_lvl[id]);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_peak[i] = 0;
            m_cnt[i] = 0;
            m_lvl[i] = 0;
        end
        expq4.delete();
        expq1.delete();
    endtask

    task automatic send4(input int s);
        sv4 = 1'b1;
        s4 = 12'(s);
        model_sample(0, s, hold4);
        @(posedge clock); #1;
        sv4 = 1'b0;
    endtask

    task automatic send1(input int s);
        sv1 = 1'b1;
        s1 = 12'(s);
        model_sample(1, s, hold1);
        @(posedge clock); #1;
        sv1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic window4(input int s);
        for (int i = 0; i < 4; i++) send4(s);
    endtask

    // Every output pulse is matched against the next model result in order
    always @(negedge clock) begin
        int e;
        if (!reset) begin
            if (lv4) begin
                pulses4++;
                if (expq4.size() == 0) check("dut4 unexpected level_valid", 1, 0);
                else begin
                    e = expq4.pop_front();
                    check("dut4 pulse level", lvl4, e);
                    check("dut4 pulse tester", t4, (1 << e) - 1);
                end
            end
            if (lv1) begin
                pulses1++;
                if (expq1.size() == 0) check("dut1 unexpected level_valid", 1, 0);
                else begin
                    e = expq1.pop_front();
                    check("dut1 pulse level", lvl1, e);
                    check("dut1 pulse tester", t1, (1 << e) - 1);
                end
            end
        end
    end

    typedef struct {
        int s;
        int lvl;
    } qvec_t;

    qvec_t qtab[9];
    int p_before;

    initial begin
        // Ascending levels so decay never masks the quantiser
        qtab[0] = '{2048, 0};   // dev 0
        qtab[1] = '{2112, 0};   // dev 64
        qtab[2] = '{1983, 1};   // dev 65
        qtab[3] = '{2239, 1};   // dev 191
        qtab[4] = '{2240, 2};   // dev 192
        qtab[5] = '{1728, 3};   // dev 320
        qtab[6] = '{4031, 15};  // dev 1983
        qtab[7] = '{64, 16};    // dev 1984
        qtab[8] = '{0, 16};     // dev 2048 clamps to 2047

        reset = 1'b1;
        sv4 = 1'b0; sv1 = 1'b0; hold4 = 1'b0; hold1 = 1'b0;
        s4 = 12'd2048; s1 = 12'd2048;
        model_reset();
        idle(3);
        reset = 1'b0;
        idle(1);

        check("reset level", lvl4, 0);
        check("reset tester", t4, 0);
        check("reset level_valid", lv4, 0);
        check("reset level dut1", lvl1, 0);

        // Small window, exact latency of the result pulse
        send4(2048); send4(2100); send4(1900); send4(2048);
        idle(1);
        check("lat t+1 no pulse", lv4, 0);
        idle(1);
        check("lat t+2 pulse", lv4, 1);
        check("lat t+2 level", lvl4, 1);
        check("lat t+2 tester", t4, 16'h0001);
        idle(1);
        check("lat t+3 pulse gone", lv4, 0);
        check("lat t+3 level held", lvl4, 1);

        // Quantisation boundaries
        for (int i = 0; i < 9; i++) begin
            window4(qtab[i].s);
            idle(3);
            check($sformatf("quant level s=%0d", qtab[i].s), lvl4, qtab[i].lvl);
            check($sformatf("quant tester s=%0d", qtab[i].s), t4, (1 << qtab[i].lvl) - 1);
        end

        // Full scale then silent windows decay one level per window
        send4(0); send4(4095); send4(2048); send4(2048);
        for (int i = 0; i < 8; i++) window4(2048);
        idle(3);
        check("decay after 8 level", lvl4, 8);
        check("decay after 8 tester", t4, 16'h00FF);
        for (int i = 0; i < 9; i++) window4(2048);
        idle(3);
        check("decay floor level", lvl4, 0);
        check("decay floor tester", t4, 0);

        // hold freezes outputs across loud windows
        window4(2368);
        idle(3);
        check("pre-hold level", lvl4, 3);
        hold4 = 1'b1;
        p_before = pulses4;
        window4(0); window4(4095);
        idle(4);
        check("hold level frozen", lvl4, 3);
        check("hold tester frozen", t4, 16'h0007);
        check("hold no pulses", pulses4 - p_before, 0);
        hold4 = 1'b0;
        window4(4095);
        idle(3);
        check("release level", lvl4, 16);
        check("release tester", t4, 16'hFFFF);

        // Reset mid-window discards the partial loud window
        send4(4095); send4(4095);
        reset = 1'b1;
        model_reset();
        #2;
        check("midreset level", lvl4, 0);
        check("midreset tester", t4, 0);
        check("midreset level_valid", lv4, 0);
        idle(2);
        reset = 1'b0;
        window4(2148);
        idle(3);
        check("post-reset window level", lvl4, 1);

        // WINDOW=1 ramp, one result per sample
        p_before = pulses1;
        for (int k = 0; k <= 16; k++) send1(2048 - k * 128);
        for (int k = 0; k < 5; k++) send1(2048);
        idle(3);
        check("dut1 ramp pulse count", pulses1 - p_before, 22);
        check("dut1 ramp final level", lvl1, 11);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            int amp, d, s;
            amp = $urandom_range(0, 2047);
            d = $urandom_range(0, amp);
            s = ($urandom_range(0, 1) != 0) ? 2048 + d : 2048 - d;
            if (s > 4095) s = 4095;
            send4(s);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        for (int n = 0; n < 200; n++) begin
            int s;
            s = $urandom_range(0, 4095);
            send1(s);
        end
        idle(4);
        check("dut4 outstanding results", expq4.size(), 0);
        check("dut1 outstanding results", expq1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
